// File: rtl/vmul_pkg.sv
// Shared types for the vALU multiplier issue path: element width, signedness select,
// issue FSM states and the credit-counter width helper.
package vmul_pkg;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    OPSEL_UU = 2'b00,
    OPSEL_US = 2'b01,
    OPSEL_SU = 2'b10,
    OPSEL_SS = 2'b11
  } opsel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS0 = 2'b01,
    PASS1 = 2'b10
  } issue_state_e;

  // Needs to hold 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vmul_lat_pipe.sv
// Fixed-latency delay line for a valid flag plus payload; payload is zeroed on idle slots
// so the output side reads all-zero whenever nothing is in flight.
module vmul_lat_pipe #(
  parameter int LATENCY = 3,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]            valid_q;
  logic [LATENCY-1:0][WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/vmul_issue_ctrl.sv
// Issue sequencer for the vALU multiplier slice: one or two passes per request, credit throttled.
// Optional VMUL_ISSUE_PERF_EN adds perf_issue_cnt / perf_stall_cnt outputs.
module vmul_issue_ctrl
  import vmul_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int TAG_WIDTH      = 4,
  parameter int MUL_LATENCY    = 3,
  parameter int RES_FIFO_DEPTH = 8,
  parameter int EN_128_MUL     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec0,
  input  logic [DATA_WIDTH-1:0] in_vec1,
  input  logic [1:0]            in_opsel,
  input  logic [1:0]            in_sew,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  os_valid,
  output logic [DATA_WIDTH-1:0] os_vec0,
  output logic [DATA_WIDTH-1:0] os_vec1,
  output logic [1:0]            os_opsel,
  output logic [1:0]            os_sew,
  output logic                  os_pass,
  output logic                  done_valid,
  output logic [TAG_WIDTH-1:0]  done_tag,
  output logic                  done_pass,
  output logic                  done_last,
  input  logic                  res_pop
`ifdef VMUL_ISSUE_PERF_EN
  ,
  output logic [31:0]           perf_issue_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int CW   = credit_width(RES_FIFO_DEPTH);
  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [CW-1:0] FULL = CW'(RES_FIFO_DEPTH);

  issue_state_e          state_q, state_d;
  logic [CW-1:0]         credits_q;
  logic [DATA_WIDTH-1:0] vec0_q, vec1_q;
  logic [1:0]            opsel_q, sew_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  two_pass_q;
  logic                  has_credit, issue, last_pass, pop_eff, accept;

  assign has_credit = (credits_q != '0);
  assign accept     = in_valid && in_ready;
  assign pop_eff    = res_pop && (credits_q != FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PASS0;
      PASS0:   if (has_credit) state_d = two_pass_q ? PASS1 : IDLE;
      PASS1:   if (has_credit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is held low while reset is asserted so every output reads 0 during reset.
  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    issue     = (state_q != IDLE) && has_credit;
    os_valid  = issue;
    os_pass   = (state_q == PASS1);
    last_pass = (state_q == PASS1) || !two_pass_q;
    os_vec1   = vec1_q;
    if (state_q == PASS1) os_vec1 = {vec1_q[HALF-1:0], vec1_q[DATA_WIDTH-1:HALF]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec0_q     <= '0;
      vec1_q     <= '0;
      opsel_q    <= '0;
      sew_q      <= '0;
      tag_q      <= '0;
      two_pass_q <= 1'b0;
    end else if (accept) begin
      vec0_q     <= in_vec0;
      vec1_q     <= in_vec1;
      opsel_q    <= in_opsel;
      sew_q      <= in_sew;
      tag_q      <= in_tag;
      two_pass_q <= (sew_e'(in_sew) == SEW_64) && (EN_128_MUL == 0);
    end
  end

  assign os_vec0  = vec0_q;
  assign os_opsel = opsel_q;
  assign os_sew   = sew_q;

  // A pop returning a credit in the same cycle as an issue cancels out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  credits_q <= FULL;
    else if (issue && !pop_eff)  credits_q <= credits_q - CW'(1);
    else if (pop_eff && !issue)  credits_q <= credits_q + CW'(1);
  end

  vmul_lat_pipe #(
    .LATENCY (MUL_LATENCY),
    .WIDTH   (TAG_WIDTH + 2)
  ) u_lat_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_data   ({tag_q, os_pass, last_pass}),
    .out_valid (done_valid),
    .out_data  ({done_tag, done_pass, done_last})
  );

`ifdef VMUL_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((state_q != IDLE) && !has_credit) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Self-checking bench for vmul_issue_ctrl: a transaction-level model (pass queue, credit count,
// completion schedule) compared every cycle, plus directed literal checks.
module tb_vmul_issue_ctrl;

  localparam int DW    = 64;
  localparam int TW    = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;
  localparam int EN128 = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_vec0, in_vec1;
  logic [1:0]    in_opsel, in_sew;
  logic [TW-1:0] in_tag;
  logic          os_valid;
  logic [DW-1:0] os_vec0, os_vec1;
  logic [1:0]    os_opsel, os_sew;
  logic          os_pass;
  logic          done_valid;
  logic [TW-1:0] done_tag;
  logic          done_pass, done_last;
  logic          res_pop;
`ifdef VMUL_ISSUE_PERF_EN
  logic [31:0]   perf_issue_cnt, perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vmul_issue_ctrl #(
    .DATA_WIDTH     (DW),
    .TAG_WIDTH      (TW),
    .MUL_LATENCY    (LAT),
    .RES_FIFO_DEPTH (DEPTH),
    .EN_128_MUL     (EN128)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec0    (in_vec0),
    .in_vec1    (in_vec1),
    .in_opsel   (in_opsel),
    .in_sew     (in_sew),
    .in_tag     (in_tag),
    .os_valid   (os_valid),
    .os_vec0    (os_vec0),
    .os_vec1    (os_vec1),
    .os_opsel   (os_opsel),
    .os_sew     (os_sew),
    .os_pass    (os_pass),
    .done_valid (done_valid),
    .done_tag   (done_tag),
    .done_pass  (done_pass),
    .done_last  (done_last),
    .res_pop    (res_pop)
`ifdef VMUL_ISSUE_PERF_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pending passes of the held request, free credits, and scheduled completions.
  typedef struct {
    logic [DW-1:0] v0, v1;
    logic [1:0]    opsel, sew;
    logic [TW-1:0] tag;
    logic          pass, last;
  } pass_t;

  typedef struct {
    int            due;
    logic [TW-1:0] tag;
    logic          pass, last;
  } done_t;

  pass_t pend_q[$];
  done_t done_q[$];
  int    credits = DEPTH;
  int    cyc = 0;
  pass_t mp;
  done_t md;
  logic  exp_ready, exp_os_valid, exp_done_valid, pop_ok;
  int    npass;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend_q.delete();
      done_q.delete();
      credits = DEPTH;
    end
    exp_ready      = rst_n && (pend_q.size() == 0);
    exp_os_valid   = rst_n && (pend_q.size() != 0) && (credits > 0);
    exp_done_valid = rst_n && (done_q.size() != 0) && (done_q[0].due == cyc);
    checkOutput("in_ready", in_ready, exp_ready);
    checkOutput("os_valid", os_valid, exp_os_valid);
    checkOutput("done_valid", done_valid, exp_done_valid);
    if (exp_os_valid) begin
      checkOutput("os_vec0", os_vec0, pend_q[0].v0);
      checkOutput("os_vec1", os_vec1, pend_q[0].v1);
      checkOutput("os_opsel", os_opsel, pend_q[0].opsel);
      checkOutput("os_sew", os_sew, pend_q[0].sew);
      checkOutput("os_pass", os_pass, pend_q[0].pass);
    end
    if (exp_done_valid) begin
      checkOutput("done_tag", done_tag, done_q[0].tag);
      checkOutput("done_pass", done_pass, done_q[0].pass);
      checkOutput("done_last", done_last, done_q[0].last);
    end
    if (!rst_n) begin
      checkOutput("rst_os_vec0", os_vec0, 0);
      checkOutput("rst_os_vec1", os_vec1, 0);
      checkOutput("rst_os_fields", {os_opsel, os_sew, os_pass}, 0);
      checkOutput("rst_done_fields", {done_tag, done_pass, done_last}, 0);
    end else begin
      pop_ok = res_pop && (credits < DEPTH);
      if (exp_done_valid) void'(done_q.pop_front());
      if (exp_os_valid) begin
        mp = pend_q.pop_front();
        md.due = cyc + LAT;
        md.tag = mp.tag;
        md.pass = mp.pass;
        md.last = mp.last;
        done_q.push_back(md);
      end
      if (exp_os_valid && !pop_ok) credits--;
      else if (pop_ok && !exp_os_valid) credits++;
      if (in_valid && exp_ready) begin
        npass = (in_sew == 2'b11 && EN128 == 0) ? 2 : 1;
        for (int k = 0; k < npass; k++) begin
          mp.v0 = in_vec0;
          mp.v1 = (k == 1) ? {in_vec1[31:0], in_vec1[63:32]} : in_vec1;
          mp.opsel = in_opsel;
          mp.sew = in_sew;
          mp.tag = in_tag;
          mp.pass = (k == 1);
          mp.last = (k == npass - 1);
          pend_q.push_back(mp);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [63:0] v0, input logic [63:0] v1,
                               input logic [1:0] opsel, input logic [1:0] sew,
                               input logic [3:0] tag);
    int guard = 0;
    in_vec0  = v0;
    in_vec1  = v1;
    in_opsel = opsel;
    in_sew   = sew;
    in_tag   = tag;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic popCycles(input int n);
    res_pop = 1'b1;
    repeat (n) @(posedge clk);
    #1 res_pop = 1'b0;
  endtask

  task automatic fillAndCheckStall(input int n, input string name);
    for (int i = 0; i < n; i++)
      applyStimulus(64'h0123_4567_89ab_cdef + 64'(i), 64'hfeed_0000_0000_0000 + 64'(i),
                    2'(i), 2'(i % 3), 4'(i));
    applyStimulus(64'hdead_beef_0000_0001, 64'hcafe_f00d_0000_0002, 2'b11, 2'b00, 4'hf);
    @(negedge clk);
    checkOutput(name, {os_valid, in_ready}, 2'b00);
    @(posedge clk);
    #1;
  endtask

  int seen;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_vec0 = '0;
    in_vec1 = '0;
    in_opsel = '0;
    in_sew = '0;
    in_tag = '0;
    res_pop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {in_ready, os_valid, done_valid, os_pass}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single pass, sew=e32, tag 3.
    applyStimulus(64'ha5a5_a5a5_5a5a_5a5a, 64'h0f0f_0f0f_f0f0_f0f0, 2'b01, 2'b10, 4'd3);
    @(negedge clk);
    checkOutput("t1_issue", {os_valid, os_pass, os_sew}, {1'b1, 1'b0, 2'b10});
    repeat (LAT) @(negedge clk);
    checkOutput("t1_done", {done_valid, done_tag, done_last}, {1'b1, 4'd3, 1'b1});
    @(posedge clk);
    #1;

    // Two-pass sew=e64 with half swap on pass 1.
    applyStimulus(64'h9999_8888_7777_6666, 64'h1111_2222_3333_4444, 2'b11, 2'b11, 4'd5);
    @(negedge clk);
    checkOutput("t2_p0_vec1", os_vec1, 64'h1111_2222_3333_4444);
    @(negedge clk);
    checkOutput("t2_p1_vec1", os_vec1, 64'h3333_4444_1111_2222);
    checkOutput("t2_p1_flags", {os_valid, os_pass}, 2'b11);
    repeat (LAT - 1) @(negedge clk);
    checkOutput("t2_done_p0", {done_valid, done_pass, done_last}, 3'b100);
    @(negedge clk);
    checkOutput("t2_done_p1", {done_valid, done_pass, done_last}, 3'b111);
    @(posedge clk);
    #1;

    // Exhaust the 5 remaining credits, then a stall released by one pop.
    for (int i = 0; i < 5; i++)
      applyStimulus(64'h10 * 64'(i + 1), 64'h20 * 64'(i + 1), 2'b00, 2'b00, 4'(i + 6));
    applyStimulus(64'h5555, 64'h6666, 2'b10, 2'b01, 4'd12);
    @(negedge clk);
    checkOutput("t3_stall", {os_valid, in_ready}, 2'b00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 res_pop = 1'b1;
    @(negedge clk);
    checkOutput("t3_stall_on_pop", os_valid, 1'b0);
    @(posedge clk);
    #1 res_pop = 1'b0;
    @(negedge clk);
    checkOutput("t3_issue_after_pop", os_valid, 1'b1);
    @(posedge clk);
    #1;
`ifdef VMUL_ISSUE_PERF_EN
    checkOutput("perf_issue_cnt", perf_issue_cnt, 32'd9);
    checkOutput("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif

    // Issue and pop together at one credit leaves one credit.
    popCycles(1);
    applyStimulus(64'h1, 64'h2, 2'b00, 2'b00, 4'd1);
    res_pop = 1'b1;
    @(posedge clk);
    #1 res_pop = 1'b0;
    applyStimulus(64'h3, 64'h4, 2'b01, 2'b01, 4'd2);
    @(negedge clk);
    checkOutput("t4_credit_kept", os_valid, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(64'h5, 64'h6, 2'b10, 2'b10, 4'd4);
    @(negedge clk);
    checkOutput("t4_credits_empty", os_valid, 1'b0);
    @(posedge clk);
    #1;
    // Excess pops at full credits must be ignored: exactly 8 issues fit afterwards.
    popCycles(12);
    fillAndCheckStall(8, "t4_full_credits_stall");

    // Reset while pass 1 is pending and two passes are in the pipe.
    popCycles(4);
    applyStimulus(64'haaaa, 64'hbbbb, 2'b00, 2'b00, 4'd10);
    applyStimulus(64'hcccc, 64'h0000_dddd_0000_eeee, 2'b11, 2'b11, 4'd11);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_outputs", {os_valid, done_valid, in_ready, os_pass}, 0);
    checkOutput("t5_rst_vec0", os_vec0, 0);
`ifdef VMUL_ISSUE_PERF_EN
    checkOutput("t5_rst_perf", {perf_issue_cnt, perf_stall_cnt}, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_valid) seen++;
    end
    checkOutput("t5_no_done_after_reset", 64'(seen), 0);
    @(posedge clk);
    #1;
    fillAndCheckStall(8, "t5_credits_restored");
    popCycles(1);
    repeat (LAT + 3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
